// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage.
// Carry ripples through registered stage boundaries; valid/ready in and out.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, discards all in-flight ops
//   in_valid  operand bundle valid          in_ready  unit accepts this cycle
//   a, b      operands (WIDTH)              sub       0: a+b, 1: a-b
//   out_valid result valid                  out_ready downstream accepts result
//   sum       result mod 2^WIDTH            cout      carry out of MSB
//   ovf       signed overflow
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;

    if (CHUNK < 1 || WIDTH % CHUNK != 0 || STAGES < 1 || STAGES > 32) begin : g_bad_param
        $error("addsub_pipe: WIDTH must be a multiple of CHUNK with 1..32 stages");
    end

    // One global enable: a stalled output freezes every stage, bubbles included.
    logic adv;
    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        // Operand bits still to be consumed entering this stage, and result
        // bits produced so far leaving it.
        localparam int OW = (STAGES - k) * CHUNK;
        localparam int RW = (k + 1) * CHUNK;

        logic [OW-1:0]  pa;
        logic [OW-1:0]  pb;
        logic           pc;
        logic           pv;
        logic [RW-1:0]  res_d;
        logic [CHUNK:0] t;

        logic [RW-1:0]  res_q;
        logic           c_q;
        logic           v_q;

        assign t = {1'b0, pa[CHUNK-1:0]} + {1'b0, pb[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, pc};

        if (k == 0) begin : g_in
            // B is inverted at entry; the subtract "+1" enters as carry-in.
            assign pa    = a;
            assign pb    = b ^ {WIDTH{sub}};
            assign pc    = sub;
            assign pv    = in_valid;
            assign res_d = t[CHUNK-1:0];
        end else begin : g_in
            assign pa    = g_st[k-1].g_fwd.a_q;
            assign pb    = g_st[k-1].g_fwd.b_q;
            assign pc    = g_st[k-1].c_q;
            assign pv    = g_st[k-1].v_q;
            // New slice lands on top of the lower slices already computed.
            assign res_d = {t[CHUNK-1:0], g_st[k-1].res_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (adv) begin
                v_q   <= pv;
                c_q   <= t[CHUNK];
                res_q <= res_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Only the not-yet-consumed upper operand slices travel on.
            logic [OW-CHUNK-1:0] a_q;
            logic [OW-CHUNK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= pa[OW-1:CHUNK];
                    b_q <= pb[OW-1:CHUNK];
                end
            end
        end else begin : g_last
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= pa[CHUNK-1] ^ pb[CHUNK-1] ^ t[CHUNK-1] ^ t[CHUNK];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].res_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and random checks of addsub_pipe in three
// configurations (32/8, 32/32, 16/4).
module tb_addsub_pipe;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;

    // main: WIDTH=32 CHUNK=8
    logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, sum;
    // p_: WIDTH=32 CHUNK=32
    logic        p_in_valid, p_in_ready, p_sub, p_out_valid, p_out_ready, p_cout, p_ovf;
    logic [31:0] p_a, p_b, p_sum;
    // h_: WIDTH=16 CHUNK=4
    logic        h_in_valid, h_in_ready, h_sub, h_out_valid, h_out_ready, h_cout, h_ovf;
    logic [15:0] h_a, h_b, h_sum;

    addsub_pipe #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    addsub_pipe #(.WIDTH(32), .CHUNK(32)) dut_p (
        .clk(clk), .rst(rst), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .a(p_a), .b(p_b), .sub(p_sub), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .sum(p_sum), .cout(p_cout), .ovf(p_ovf)
    );

    addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid),
        .out_ready(h_out_ready), .sum(h_sum), .cout(h_cout), .ovf(h_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          t;
    } exp_t;

    // Reference: {ovf, cout, sum}; ovf from the operand/result sign rule.
    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        logic [32:0] r;
        logic        v;
        r = {1'b0, x} + {1'b0, (s ? ~y : y)} + {32'd0, s};
        if (s) v = (x[31] != y[31]) && (r[31] != x[31]);
        else   v = (x[31] == y[31]) && (r[31] != x[31]);
        return {v, r};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || sum !== 32'd0 || in_ready !== 1'b1 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got v=%b sum=%h rdy=%b c=%b o=%b want 0 0 1 0 0",
                     out_valid, sum, in_ready, cout, ovf);
        end
        checks++;
        if (p_out_valid !== 1'b0 || p_sum !== 32'd0 || h_out_valid !== 1'b0 ||
            h_sum !== 16'd0 || p_in_ready !== 1'b1 || h_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_alt got pv=%b psum=%h hv=%b hsum=%h want 0 0 0 0",
                     p_out_valid, p_sum, h_out_valid, h_sum);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle%0d got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic [31:0] es [4];
        logic        ec [4];
        logic        eo [4];
        va = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000};
        vb = '{32'h00000001, 32'h00000001, 32'd7, 32'h00000001};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
        ec = '{1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t < 4) begin
                in_valid = 1'b1; a = va[t]; b = vb[t]; sub = vs[t];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (t >= 4 && t < 8) begin
                if (out_valid !== 1'b1 || sum !== es[t-4] ||
                    cout !== ec[t-4] || ovf !== eo[t-4]) begin
                    failures++;
                    $display("FAIL dir%0d got v=%b sum=%h c=%b o=%b want 1 %h %b %b",
                             t - 4, out_valid, sum, cout, ovf, es[t-4], ec[t-4], eo[t-4]);
                end
            end else if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL dir_idle t=%0d got out_valid=%b want 0", t, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t        q[$];
        int          idx;
        int          rcv;
        int          t;
        logic        stalled;
        logic [31:0] held;
        logic [33:0] m;
        exp_t        e;
        idx = 0; rcv = 0; t = 0; stalled = 1'b0; held = '0;
        while (rcv < 6 && t < 40) begin
            @(negedge clk);
            out_ready = !(t >= 5 && t <= 7);
            if (idx < 6) begin
                in_valid = 1'b1;
                a = 32'h11111111 * (idx + 1) + 32'hF0;
                b = 32'h0F0F0F0F + idx;
                sub = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failures++;
                $display("FAIL bp_in_ready t=%0d got %b want %b", t, in_ready,
                         !(out_valid && !out_ready));
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== held) begin
                    failures++;
                    $display("FAIL bp_hold t=%0d got v=%b sum=%h want 1 %h",
                             t, out_valid, sum, held);
                end
            end
            stalled = out_valid && !out_ready;
            held    = sum;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got sum=%h want no result", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
                        failures++;
                        $display("FAIL bp_res%0d got %h %b %b want %h %b %b",
                                 rcv, sum, cout, ovf, e.s, e.c, e.o);
                    end
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                m = model32(a, b, sub);
                q.push_back('{s: m[31:0], c: m[32], o: m[33], t: cyc});
                idx++;
            end
            t++;
        end
        checks++;
        if (rcv != 6) begin
            failures++;
            $display("FAIL bp_count got %0d want 6", rcv);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL bp_dup%0d got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            rst = (t == 3);
            in_valid = (t < 3) || (t == 5);
            a = (t == 5) ? 32'd3 : 32'hA0000000 + t;
            b = (t == 5) ? 32'd4 : 32'h0000000B;
            sub = 1'b0;
            #1;
            if (t >= 4) begin
                checks++;
                if (t == 9) begin
                    if (out_valid !== 1'b1 || sum !== 32'd7 || cout !== 1'b0 ||
                        ovf !== 1'b0) begin
                        failures++;
                        $display("FAIL rstmid_new got v=%b sum=%h want 1 00000007",
                                 out_valid, sum);
                    end
                end else if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_leak t=%0d got v=%b sum=%h want 0",
                             t, out_valid, sum);
                end
            end
        end
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [33:0] m;
        int          issued;
        int          got;
        int          minlat;
        int          cycles;
        issued = 0; got = 0; minlat = 1 << 30; cycles = 0;
        in_valid = 1'b0;
        while ((issued < 5000 || q.size() != 0) && cycles < 30000) begin
            @(negedge clk);
            if (!in_valid || (in_valid && in_ready)) begin
                in_valid = (issued < 5000) && ($urandom_range(0, 9) < 8);
                a = $urandom;
                b = $urandom;
                sub = $urandom_range(0, 1) == 1;
            end
            out_ready = $urandom_range(0, 9) < 7;
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_extra got sum=%h want no result", sum);
                end else begin
                    e = q.pop_front();
                    if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
                        failures++;
                        $display("FAIL rnd%0d got %h %b %b want %h %b %b",
                                 got, sum, cout, ovf, e.s, e.c, e.o);
                    end
                    if (cyc - e.t < minlat) minlat = cyc - e.t;
                end
                got++;
            end
            if (in_valid && in_ready) begin
                m = model32(a, b, sub);
                q.push_back('{s: m[31:0], c: m[32], o: m[33], t: cyc});
                issued++;
            end
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != 5000 || q.size() != 0) begin
            failures++;
            $display("FAIL rnd_count got %0d pending %0d want 5000 0", got, q.size());
        end
        checks++;
        if (minlat != 4) begin
            failures++;
            $display("FAIL rnd_min_latency got %0d want 4", minlat);
        end
    endtask

    task automatic test_chunk32();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic [31:0] es [4];
        logic        ec [4];
        logic        eo [4];
        va = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'd5, 32'h80000000};
        vb = '{32'h00000001, 32'h00000001, 32'd7, 32'h00000001};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h7FFFFFFF};
        ec = '{1'b1, 1'b0, 1'b0, 1'b1};
        eo = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            if (t < 4) begin
                p_in_valid = 1'b1; p_a = va[t]; p_b = vb[t]; p_sub = vs[t];
            end else begin
                p_in_valid = 1'b0;
            end
            #1;
            checks++;
            if (t >= 1 && t < 5) begin
                if (p_out_valid !== 1'b1 || p_sum !== es[t-1] ||
                    p_cout !== ec[t-1] || p_ovf !== eo[t-1]) begin
                    failures++;
                    $display("FAIL c32_%0d got v=%b sum=%h c=%b o=%b want 1 %h %b %b",
                             t - 1, p_out_valid, p_sum, p_cout, p_ovf,
                             es[t-1], ec[t-1], eo[t-1]);
                end
            end else if (p_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL c32_idle t=%0d got out_valid=%b want 0", t, p_out_valid);
            end
        end
    endtask

    task automatic test_w16();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vs [4];
        logic [15:0] es [4];
        logic        ec [4];
        logic        eo [4];
        va = '{16'h7FFF, 16'hFFFF, 16'd5, 16'h8000};
        vb = '{16'h0001, 16'h0001, 16'd7, 16'h0001};
        vs = '{1'b0, 1'b0, 1'b1, 1'b1};
        es = '{16'h8000, 16'h0000, 16'hFFFE, 16'h7FFF};
        ec = '{1'b0, 1'b1, 1'b0, 1'b1};
        eo = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t < 4) begin
                h_in_valid = 1'b1; h_a = va[t]; h_b = vb[t]; h_sub = vs[t];
            end else begin
                h_in_valid = 1'b0;
            end
            #1;
            checks++;
            if (t >= 4 && t < 8) begin
                if (h_out_valid !== 1'b1 || h_sum !== es[t-4] ||
                    h_cout !== ec[t-4] || h_ovf !== eo[t-4]) begin
                    failures++;
                    $display("FAIL w16_%0d got v=%b sum=%h c=%b o=%b want 1 %h %b %b",
                             t - 4, h_out_valid, h_sum, h_cout, h_ovf,
                             es[t-4], ec[t-4], eo[t-4]);
                end
            end else if (h_out_valid !== 1'b0) begin
                failures++;
                $display("FAIL w16_idle t=%0d got out_valid=%b want 0", t, h_out_valid);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        p_in_valid = 1'b0; p_a = '0; p_b = '0; p_sub = 1'b0; p_out_ready = 1'b1;
        h_in_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_chunk32();
        test_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
